// File: rtl/tcam_ctrl_pkg.sv
// Shared definitions for the TCAM request controller: command encodings,
// FSM state type and default geometry.
package tcam_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PROBE = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/tcam_free_finder.sv
// Lowest-free-slot finder: priority encoder returning the lowest index whose
// valid bit is clear, plus a flag saying whether any such slot exists.
module tcam_free_finder
  import tcam_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [(1<<ADDR_W)-1:0] valid,
  output logic [ADDR_W-1:0]      free_idx,
  output logic                   any_free
);

  // Scan from the top down so the last hit written is the lowest free index.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = (1 << ADDR_W) - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = ADDR_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcam_ctrl.sv
// Request controller in front of a ternary CAM. Serialises lookup, insert and
// delete commands, tracks which TCAM entries are valid, and picks the slot
// for each insert (in-place update, lowest free slot, or replacement).
// Optional feature: define TCAM_CTRL_REPLACE_EN to enable round-robin
// replacement when inserting into a full table; otherwise such an insert
// responds with rsp_err.
// Handshakes: a command transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on an edge where rsp_valid
// and rsp_ready are both high. rsp_* fields are held stable while rsp_valid.
module tcam_ctrl
  import tcam_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_key,
  input  logic [DATA_W-1:0] req_mask,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic [DATA_W-1:0] tcam_data,
  output logic [DATA_W-1:0] tcam_mask,
  output logic              tcam_wr,
  output logic [ADDR_W-1:0] tcam_waddr,
  input  logic              tcam_hit,
  input  logic [ADDR_W-1:0] tcam_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e            state_q, state_d;
  op_e               op_q;
  op_e               req_op_e;
  logic [DATA_W-1:0] key_q, mask_q;
  logic [ADDR_W-1:0] target_q;
  logic              upd_q;
  logic              rsp_hit_q, rsp_err_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              qhit;
  logic [ADDR_W-1:0] free_idx;
  logic              any_free;
`ifdef TCAM_CTRL_REPLACE_EN
  logic [ADDR_W-1:0] victim_q;
`endif

  assign req_op_e = op_e'(req_op);

  // A TCAM hit only counts if the matching entry holds live data.
  assign qhit = tcam_hit && valid_q[tcam_addr];

  tcam_free_finder #(.ADDR_W(ADDR_W)) u_free_finder (
    .valid    (valid_q),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign tcam_wr    = (state_q == WRITE);
  assign tcam_waddr = target_q;
  assign tcam_data  = key_q;
  assign tcam_mask  = mask_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_addr   = rsp_addr_q;
  assign occupancy  = occ_q;
  assign full       = (occ_q == (ADDR_W+1)'(DEPTH));

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_op_e == OP_LOOKUP || req_op_e == OP_INSERT) state_d = PROBE;
          else                                                state_d = RESP;
        end
      end
      PROBE: begin
        if (op_q == OP_INSERT) begin
`ifdef TCAM_CTRL_REPLACE_EN
          state_d = WRITE;
`else
          state_d = (qhit || any_free) ? WRITE : RESP;
`endif
        end else begin
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valid bitmap and its popcount move together so occupancy never lags.
  always_comb begin
    valid_d = valid_q;
    if (state_q == IDLE && req_valid && req_op_e == OP_DELETE) valid_d[req_addr] = 1'b0;
    if (state_q == WRITE) valid_d[target_q] = 1'b1;
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + (ADDR_W+1)'(valid_d[i]);
  end

  // Bitmap and occupancy registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Command latch, slot selection and response fields.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_q       <= OP_LOOKUP;
      key_q      <= '0;
      mask_q     <= '0;
      target_q   <= '0;
      upd_q      <= 1'b0;
      rsp_hit_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_addr_q <= '0;
`ifdef TCAM_CTRL_REPLACE_EN
      victim_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op_e;
            key_q      <= req_key;
            mask_q     <= req_mask;
            upd_q      <= 1'b0;
            rsp_hit_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_addr_q <= '0;
            if (req_op_e == OP_DELETE) begin
              rsp_hit_q  <= valid_q[req_addr];
              rsp_addr_q <= req_addr;
            end else if (req_op_e == OP_RSVD) begin
              rsp_err_q  <= 1'b1;
            end
          end
        end
        PROBE: begin
          if (op_q == OP_LOOKUP) begin
            rsp_hit_q  <= qhit;
            rsp_addr_q <= qhit ? tcam_addr : '0;
          end else if (qhit) begin
            target_q <= tcam_addr;
            upd_q    <= 1'b1;
          end else if (any_free) begin
            target_q <= free_idx;
            upd_q    <= 1'b0;
          end else begin
`ifdef TCAM_CTRL_REPLACE_EN
            target_q <= victim_q;
            upd_q    <= 1'b0;
            victim_q <= victim_q + 1'b1;
`else
            rsp_err_q <= 1'b1;
`endif
          end
        end
        WRITE: begin
          rsp_hit_q  <= upd_q;
          rsp_addr_q <= target_q;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
